// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, FSM state type and bit-permutation helpers.
// Bit numbering follows DES: DES bit 1 is the MSB of each vector.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Entry i is the rotate amount of round i+1.
  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_TAB[i]];
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] sk;
    sk = '0;
    for (int i = 0; i < 48; i++) sk[47-i] = cd[56-PC2_TAB[i]];
    return sk;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Single DES runs one pass in the job direction; 3DES EDE flips the middle pass.
  function automatic logic pass_is_dec(input logic decrypt, input logic [1:0] pass_idx);
    return decrypt ^ (pass_idx == 2'd1);
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC2 compression of the C,D register pair into a 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  assign subkey = pc2(cd);

endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES/3DES round-key generator: one 48-bit subkey per handshake,
// in encrypt, decrypt or 3DES EDE consumption order.
module des_key_sched_seq
  import des_pkg::*;
#(
  parameter int NUM_KEYS     = 1,
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_valid,
  output logic                     key_ready,
  input  logic [64*NUM_KEYS-1:0]   key_in,
  input  logic                     decrypt,
  input  logic                     abort,
  output logic                     sk_valid,
  input  logic                     sk_ready,
  output logic [47:0]              subkey,
  output logic [3:0]               round_idx,
  output logic [1:0]               pass_idx,
  output logic                     sk_last,
  output logic                     parity_err
);

  localparam int         KW        = 64 * NUM_KEYS;
  localparam logic [1:0] LAST_PASS = 2'(NUM_KEYS - 1);

  if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
    $error("des_key_sched_seq: NUM_KEYS must be 1 or 3");
  end

  state_t        state, state_nxt;
  logic [KW-1:0] key_q;
  logic          dec_q;
  logic [27:0]   c_q, d_q;
  logic [3:0]    round_q;
  logic [1:0]    pass_q;
  logic          par_q;

  logic          accept, advance, pass_end;
  logic [1:0]    key_sel;
  logic [63:0]   pass_key;
  logic [55:0]   pc1_cd;
  logic          pass_dec;
  logic [1:0]    shift_amt;
  logic          key_par_bad;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    pass_end  = 1'b0;
    case (state)
      IDLE: if (key_valid) begin
        accept    = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN: if (sk_ready) begin
        if (round_q == 4'd15) begin
          pass_end  = 1'b1;
          state_nxt = (pass_q == LAST_PASS) ? IDLE : LOAD;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Cancel wins over any handshake or accept in the same cycle.
    if (abort) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      advance   = 1'b0;
      pass_end  = 1'b0;
    end
  end

  // Decrypting jobs walk the key list backwards.
  assign key_sel   = dec_q ? (LAST_PASS - pass_q) : pass_q;
  assign pass_key  = key_q[64*key_sel +: 64];
  assign pc1_cd    = pc1(pass_key);
  assign pass_dec  = pass_is_dec(dec_q, pass_q);
  assign shift_amt = pass_dec ? SHIFT_TAB[4'd15 - round_q] : SHIFT_TAB[round_q + 4'd1];

  always_comb begin
    key_par_bad = 1'b0;
    for (int i = 0; i < 8 * NUM_KEYS; i++) key_par_bad |= ~(^key_in[8*i +: 8]);
    if (!CHECK_PARITY) key_par_bad = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the key store is reset too, so no key material outlives a reset.
      state   <= IDLE;
      key_q   <= '0;
      dec_q   <= 1'b0;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      pass_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      if (accept) begin
        key_q   <= key_in;
        dec_q   <= decrypt;
        par_q   <= key_par_bad;
        round_q <= '0;
        pass_q  <= '0;
      end
      // C,D always hold the pair whose PC2 is the subkey on display.
      if (state == LOAD) begin
        c_q <= pass_dec ? pc1_cd[55:28] : rotl28(pc1_cd[55:28], SHIFT_TAB[0]);
        d_q <= pass_dec ? pc1_cd[27:0]  : rotl28(pc1_cd[27:0],  SHIFT_TAB[0]);
      end
      if (advance) begin
        round_q <= round_q + 4'd1;
        c_q     <= pass_dec ? rotr28(c_q, shift_amt) : rotl28(c_q, shift_amt);
        d_q     <= pass_dec ? rotr28(d_q, shift_amt) : rotl28(d_q, shift_amt);
      end
      if (pass_end) begin
        round_q <= '0;
        pass_q  <= (pass_q == LAST_PASS) ? 2'd0 : pass_q + 2'd1;
      end
      if (abort) begin
        round_q <= '0;
        pass_q  <= '0;
      end
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

  assign key_ready  = (state == IDLE);
  assign sk_valid   = (state == RUN);
  assign round_idx  = round_q;
  assign pass_idx   = pass_q;
  assign sk_last    = sk_valid && (round_q == 4'd15) && (pass_q == LAST_PASS);
  assign parity_err = par_q;

endmodule
